// File: rtl/result_bram_if.sv
// BRAM port-B read bus and output stream of the result reader.
interface result_bram_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 16
);
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output bram_en, bram_addr,
        input  bram_dout,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  bram_en, bram_addr,
        output bram_dout,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/result_bram_reader.sv
// Strided result-BRAM reader feeding a valid/ready stream through a
// credit-limited prefetch FIFO.
module result_bram_reader #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [CNT_W-1:0]  i_num_words,
    output logic              o_busy,
    output logic              o_done,
    result_bram_if.master     bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_issued;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last;
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [PW:0]           r_count;

    logic w_credit;
    logic w_issue;
    logic w_issue_last;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Buffered plus in-flight words may never exceed the FIFO capacity.
    assign w_credit     = (int'(r_count) + int'(r_inflight)) < FIFO_DEPTH;
    assign w_issue      = (r_state == S_READ) && (r_issued < r_num) && w_credit;
    assign w_issue_last = w_issue && (r_issued == r_num - CNT_W'(1));
    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_push       = r_inflight;
    assign w_pop        = bus.m_valid && bus.m_ready;

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_words == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                o_busy = 1'b1;
                if (w_issue_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (w_pop && bus.m_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_stride        <= '0;
            r_next_addr     <= '0;
            r_last_addr     <= '0;
            r_num           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_accept) begin
                r_stride    <= i_stride;
                r_num       <= i_num_words;
                r_next_addr <= i_base_addr;
                r_issued    <= '0;
            end else if (w_issue) begin
                r_next_addr <= r_next_addr + r_stride;
                r_last_addr <= r_next_addr;
                r_issued    <= r_issued + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_last[r_wr] <= r_inflight_last;
                r_wr         <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= bus.bram_dout;
    end

    // Address output holds the last issued address while idle.
    assign bus.bram_en   = w_issue;
    assign bus.bram_addr = w_issue ? r_next_addr : r_last_addr;
    assign bus.m_valid   = (r_count != '0);
    assign bus.m_data    = bus.m_valid ? r_mem[r_rd] : '0;
    assign bus.m_last    = bus.m_valid && r_last[r_rd];

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_count == (PW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_result_bram_reader.sv
// Self-checking bench for result_bram_reader: table vectors, random
// transfers against a queue-based reference model, and reset corner cases.
module tb_result_bram_reader;
    localparam int DW = 256;
    localparam int AW = 16;
    localparam int CW = 9;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy;
    logic          done;

    result_bram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    result_bram_reader #(
        .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_stride    (stride),
        .i_num_words (num_words),
        .o_busy      (busy),
        .o_done      (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: sparse preloaded contents, address-derived elsewhere
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{a ^ 16'h5A3C, a}};
    endfunction

    always @(posedge clk) if (bus.bram_en) bus.bram_dout <= rd(bus.bram_addr);

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    bit            mon_on = 1'b0;
    logic [AW-1:0] q_addr[$];
    logic [DW:0]   q_beat[$];
    logic [DW:0]   mon_b;
    int            t0, en_cnt, beats, done_cnt, done_rel, fv_rel, busy_seen;
    int            cur_num;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    always @(negedge clk) if (mon_on) begin
        if (bus.bram_en) begin
            en_cnt++;
            chk("en_while_busy", busy, 1);
            if (q_addr.size() == 0) chk("issue_count", en_cnt, cur_num);
            else chk("bram_addr", bus.bram_addr, q_addr.pop_front());
        end
        if (busy) busy_seen++;
        if (bus.m_valid && fv_rel < 0) fv_rel = cyc - t0;
        if (bus.m_valid && prev_stall) chk("stall_hold", bus.m_data, prev_data);
        if (bus.m_valid && bus.m_ready) begin
            beats++;
            if (q_beat.size() == 0) chk("beat_count", beats, cur_num);
            else begin
                mon_b = q_beat.pop_front();
                chk("m_data", bus.m_data, mon_b[DW-1:0]);
                chk("m_last", bus.m_last, mon_b[DW]);
            end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        if (done) begin
            done_cnt++;
            done_rel = cyc - t0;
            chk("done_fifo_empty", bus.m_valid, 0);
        end
    end

    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return (rel % 2) == 1;
            2:       return !(rel >= 1 && rel <= 12);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input logic [CW-1:0] n, input int mode,
                            input bit dup, input int exp_fv,
                            input int exp_done);
        int rel;
        int lim;
        int en_at12;
        q_addr.delete();
        q_beat.delete();
        for (int k = 0; k < int'(n); k++) begin
            logic [AW-1:0] a;
            a = b + AW'(k) * s;
            q_addr.push_back(a);
            q_beat.push_back({k == int'(n) - 1, rd(a)});
        end
        en_cnt = 0; beats = 0; done_cnt = 0; done_rel = -1;
        fv_rel = -1; busy_seen = 0; prev_stall = 1'b0; cur_num = int'(n);
        @(posedge clk); #1;
        base_addr = b; stride = s; num_words = n; start = 1'b1;
        t0 = cyc; mon_on = 1'b1;
        bus.m_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        lim = int'(n) * 6 + 40;
        en_at12 = -1;
        rel = cyc - t0;
        while (done_cnt == 0 && rel < lim) begin
            bus.m_ready = ready_for(mode, rel);
            if (dup && rel == 4) begin
                start = 1'b1; base_addr = ~b; num_words = 5;
            end else start = 1'b0;
            @(posedge clk); #1;
            rel = cyc - t0;
            if (rel == 13) en_at12 = en_cnt;
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mon_on = 1'b0;
        chk("done_count", done_cnt, 1);
        chk("beats", beats, int'(n));
        chk("issues", en_cnt, int'(n));
        chk("beats_left", q_beat.size(), 0);
        if (exp_fv >= 0) chk("first_valid", fv_rel, exp_fv);
        if (exp_done >= 0) chk("done_lat", done_rel, exp_done);
        if (n == 0) chk("busy_zero", busy_seen, 0);
        if (mode == 2) chk("stall_issues", en_at12, (int'(n) < FD) ? int'(n) : FD);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [CW-1:0] num;
        int            mode;
        bit            dup;
        int            exp_fv;
        int            exp_done;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{16'h0000, 16'd23,   9'd16,  0, 1'b0,  3, 19};
        vt[1] = '{16'h0000, 16'd23,   9'd16,  2, 1'b0, -1, -1};
        vt[2] = '{16'h0100, 16'd1,    9'd8,   1, 1'b0, -1, -1};
        vt[3] = '{16'hFFF0, 16'h0020, 9'd3,   0, 1'b0,  3,  6};
        vt[4] = '{16'h1234, 16'd7,    9'd0,   0, 1'b0, -1,  1};
        vt[5] = '{16'h0040, 16'd5,    9'd10,  0, 1'b1,  3, 13};
        vt[6] = '{16'h8000, 16'd9,    9'd1,   0, 1'b0,  3,  4};
        vt[7] = '{16'h0003, 16'h0101, 9'd511, 3, 1'b0, -1, -1};

        for (int i = 0; i < 16; i++) mem[AW'(i * 23)] = {16{16'(i + 1)}};

        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, done, bus.bram_en, bus.m_valid, bus.m_last,
                          bus.bram_addr}, '0);
        chk("reset_data", bus.m_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_xfer(vt[i].base, vt[i].stride, vt[i].num, vt[i].mode,
                     vt[i].dup, vt[i].exp_fv, vt[i].exp_done);

        for (int i = 0; i < 20; i++)
            run_xfer(AW'($urandom), AW'($urandom), CW'($urandom_range(0, 40)),
                     3, 1'b0, -1, -1);

        // Reset in the middle of a stalled transfer
        @(posedge clk); #1;
        base_addr = 16'h0200; stride = 16'd1; num_words = 9'd12;
        start = 1'b1; bus.m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.m_valid, 1);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_ctl", {busy, done, bus.bram_en, bus.m_valid,
                               bus.m_last, bus.bram_addr}, '0);
            chk("midrst_data", bus.m_data, '0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", bus.m_valid, 0);
        run_xfer(16'h0000, 16'd1, 9'd4, 0, 1'b0, 3, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
